// File: rtl/dotprod_pkg.sv
// Shared constants and FSM state encoding for the dot-product operand feeder.
package dotprod_pkg;

  localparam int DP_N       = 8;
  localparam int DP_W       = 32;
  localparam int DP_RW      = 2 * DP_W;
  localparam int DP_TIMEOUT = 200;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/dp_timeout_cnt.sv
// Cycle counter that bounds how long the feeder waits for the dotprod to finish.
// expired flags the cycle whose increment would bring the count to TIMEOUT,
// so the caller can leave on that same edge after exactly TIMEOUT waiting cycles.
module dp_timeout_cnt
  import dotprod_pkg::*;
#(
  parameter int TIMEOUT = DP_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise count enabled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q == LAST_CNT);

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dotprod_feeder.sv
// Collects 2N stream words into operand registers a/b, fires a one-cycle start
// to the dotprod engine, waits (bounded) for done and offers the captured result
// through a valid/ready handshake. The a0..a7/b0..b7 port list assumes N = 8.
module dotprod_feeder
  import dotprod_pkg::*;
#(
  parameter int N       = DP_N,
  parameter int W       = DP_W,
  parameter int TIMEOUT = DP_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic [W-1:0]   a0,
  output logic [W-1:0]   a1,
  output logic [W-1:0]   a2,
  output logic [W-1:0]   a3,
  output logic [W-1:0]   a4,
  output logic [W-1:0]   a5,
  output logic [W-1:0]   a6,
  output logic [W-1:0]   a7,
  output logic [W-1:0]   b0,
  output logic [W-1:0]   b1,
  output logic [W-1:0]   b2,
  output logic [W-1:0]   b3,
  output logic [W-1:0]   b4,
  output logic [W-1:0]   b5,
  output logic [W-1:0]   b6,
  output logic [W-1:0]   b7,
  output logic           start,
  input  logic           done,
  input  logic [2*W-1:0] result,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data,
  output logic           res_err
);

  localparam int RW = 2 * W;
  localparam int CW = $clog2(2 * N);
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] N_IDX    = CW'(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(2 * N - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            live_q, live_d;
  logic [W-1:0]    a_q [N];
  logic [W-1:0]    a_d [N];
  logic [W-1:0]    b_q [N];
  logic [W-1:0]    b_d [N];
  logic [RW-1:0]   res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic            accept;
  logic            tmo_clear;
  logic            tmo_enable;
  logic            tmo_expired;

  // live_q holds in_ready low until the first edge after reset is released
  assign in_ready   = live_q && (state_q == ST_LOAD);
  assign accept     = in_valid && in_ready;
  assign start      = (state_q == ST_START);
  assign res_valid  = (state_q == ST_OUT);
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign tmo_clear  = (state_q != ST_WAIT);
  assign tmo_enable = (state_q == ST_WAIT) && !done;

  dp_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Next-state logic: operand loading, start pulse, bounded wait, result hand-off
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    live_d     = 1'b1;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (cnt_q < N_IDX) begin
            a_d[IW'(cnt_q)] = in_data;
          end else begin
            b_d[IW'(cnt_q - N_IDX)] = in_data;
          end
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          res_data_d = result;
          res_err_d  = 1'b0;
          state_d    = ST_OUT;
        end else if (tmo_expired) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, counter, operand and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      live_q     <= 1'b0;
      a_q        <= '{default: '0};
      b_q        <= '{default: '0};
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      live_q     <= live_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  assign a0 = a_q[0];
  assign a1 = a_q[1];
  assign a2 = a_q[2];
  assign a3 = a_q[3];
  assign a4 = a_q[4];
  assign a5 = a_q[5];
  assign a6 = a_q[6];
  assign a7 = a_q[7];
  assign b0 = b_q[0];
  assign b1 = b_q[1];
  assign b2 = b_q[2];
  assign b3 = b_q[3];
  assign b4 = b_q[4];
  assign b5 = b_q[5];
  assign b6 = b_q[6];
  assign b7 = b_q[7];

endmodule

// File: tb/tb_dotprod_feeder.sv
// Directed bench for dotprod_feeder; the bench itself plays the dotprod engine.
module tb_dotprod_feeder;

  localparam int N       = 8;
  localparam int W       = 32;
  localparam int RW      = 2 * W;
  localparam int TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [W-1:0]  a0, a1, a2, a3, a4, a5, a6, a7;
  logic [W-1:0]  b0, b1, b2, b3, b4, b5, b6, b7;
  logic          start;
  logic          done;
  logic [RW-1:0] result;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_data;
  logic          res_err;

  int checks   = 0;
  int failures = 0;
  int n_cyc;
  logic [W-1:0] va [N];
  logic [W-1:0] vb [N];

  // Free-running clock
  always #5 clk = ~clk;

  dotprod_feeder #(
    .N       (N),
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .a4        (a4),
    .a5        (a5),
    .a6        (a6),
    .a7        (a7),
    .b0        (b0),
    .b1        (b1),
    .b2        (b2),
    .b3        (b3),
    .b4        (b4),
    .b5        (b5),
    .b6        (b6),
    .b7        (b7),
    .start     (start),
    .done      (done),
    .result    (result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine stand-in: dot product of whatever the feeder currently drives
  function automatic logic [RW-1:0] stub_dot();
    return RW'(a0) * RW'(b0) + RW'(a1) * RW'(b1) + RW'(a2) * RW'(b2) + RW'(a3) * RW'(b3)
         + RW'(a4) * RW'(b4) + RW'(a5) * RW'(b5) + RW'(a6) * RW'(b6) + RW'(a7) * RW'(b7);
  endfunction

  task automatic send_word(input logic [W-1:0] w, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check_output("ready_wait", RW'(in_ready), RW'(1'b1));
    tick();
    in_valid = 1'b0;
    in_data  = 32'hBAD0_BAD0;
  endtask

  task automatic apply_stimulus(input int max_gap);
    for (int i = 0; i < 2 * N; i++) begin
      send_word((i < N) ? va[i] : vb[i - N], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  // Called in the START cycle: checks the pulse, answers done, takes the result
  task automatic finish_normal(input string tag, input logic [RW-1:0] exp);
    check_output({tag, "_start"}, RW'(start), RW'(1'b1));
    check_output({tag, "_ready_start"}, RW'(in_ready), RW'(1'b0));
    tick();
    check_output({tag, "_start_width"}, RW'(start), RW'(1'b0));
    tick();
    check_output({tag, "_no_early_valid"}, RW'(res_valid), RW'(1'b0));
    done   = 1'b1;
    result = stub_dot();
    tick();
    done   = 1'b0;
    result = '0;
    check_output({tag, "_valid"}, RW'(res_valid), RW'(1'b1));
    check_output({tag, "_data"}, res_data, exp);
    check_output({tag, "_err"}, RW'(res_err), RW'(1'b0));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_output({tag, "_valid_drop"}, RW'(res_valid), RW'(1'b0));
    check_output({tag, "_ready_back"}, RW'(in_ready), RW'(1'b1));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    done      = 1'b0;
    result    = '0;
    res_ready = 1'b0;

    // Reset state
    #2;
    check_output("rst_in_ready", RW'(in_ready), RW'(1'b0));
    check_output("rst_start", RW'(start), RW'(1'b0));
    check_output("rst_res_valid", RW'(res_valid), RW'(1'b0));
    check_output("rst_res_data", res_data, '0);
    check_output("rst_res_err", RW'(res_err), RW'(1'b0));
    check_output("rst_a0", RW'(a0), '0);
    check_output("rst_b7", RW'(b7), '0);
    repeat (2) tick();
    rst = 1'b0;
    #2;
    check_output("post_rst_ready_low", RW'(in_ready), RW'(1'b0));
    tick();
    check_output("post_rst_ready_high", RW'(in_ready), RW'(1'b1));

    // Single vector set, answer 170
    $display("[TB] vector set 170");
    va = '{2, 7, 5, 3, 5, 6, 7, 8};
    vb = '{8, 7, 6, 5, 4, 3, 2, 1};
    apply_stimulus(0);
    check_output("load_a1", RW'(a1), RW'(32'd7));
    check_output("load_b0", RW'(b0), RW'(32'd8));
    check_output("load_a7", RW'(a7), RW'(32'd8));
    finish_normal("v170", 64'd170);

    // Back-to-back sets: 120 then 20
    $display("[TB] back-to-back 120 / 20");
    va = '{1, 2, 3, 4, 5, 6, 7, 8};
    vb = '{8, 7, 6, 5, 4, 3, 2, 1};
    apply_stimulus(0);
    finish_normal("v120", 64'd120);
    vb = '{0, 1, 0, 1, 0, 1, 0, 1};
    apply_stimulus(0);
    finish_normal("v20", 64'd20);

    // Random input gaps, consumer stalls five cycles, late done ignored
    $display("[TB] gaps and stalled consumer");
    vb = '{1, 2, 3, 4, 5, 6, 7, 8};
    apply_stimulus(3);
    check_output("gap_start", RW'(start), RW'(1'b1));
    tick();
    done   = 1'b1;
    result = stub_dot();
    tick();
    done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_output("stall_valid", RW'(res_valid), RW'(1'b1));
      check_output("stall_data", res_data, 64'd204);
      check_output("stall_in_ready", RW'(in_ready), RW'(1'b0));
      done   = (i == 2);
      result = 64'd999;
      in_valid = 1'b1;
      tick();
    end
    done     = 1'b0;
    in_valid = 1'b0;
    check_output("stall_data_end", res_data, 64'd204);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_output("stall_release", RW'(res_valid), RW'(1'b0));

    // done raised in START is ignored, WAIT result is captured
    $display("[TB] done during START");
    va = '{2, 7, 5, 3, 5, 6, 7, 8};
    vb = '{8, 7, 6, 5, 4, 3, 2, 1};
    apply_stimulus(0);
    check_output("dstart_start", RW'(start), RW'(1'b1));
    done   = 1'b1;
    result = 64'hDEAD;
    tick();
    check_output("dstart_not_out", RW'(res_valid), RW'(1'b0));
    result = stub_dot();
    tick();
    done = 1'b0;
    check_output("dstart_valid", RW'(res_valid), RW'(1'b1));
    check_output("dstart_data", res_data, 64'd170);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Engine never answers: timeout after TIMEOUT waiting cycles
    $display("[TB] timeout");
    apply_stimulus(0);
    check_output("tmo_start", RW'(start), RW'(1'b1));
    result = 64'h1234_5678;
    n_cyc  = 0;
    while (!res_valid && n_cyc < 2 * TIMEOUT) begin
      tick();
      n_cyc++;
    end
    check_output("tmo_latency", RW'(n_cyc), RW'(TIMEOUT + 1));
    check_output("tmo_err", RW'(res_err), RW'(1'b1));
    check_output("tmo_data", res_data, '0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // done arriving on the expiring cycle wins; full-width pass-through
    $display("[TB] done at timeout boundary");
    apply_stimulus(0);
    repeat (TIMEOUT) tick();
    check_output("edge_not_yet", RW'(res_valid), RW'(1'b0));
    done   = 1'b1;
    result = 64'hFEDC_BA98_7654_3210;
    tick();
    done = 1'b0;
    check_output("edge_valid", RW'(res_valid), RW'(1'b1));
    check_output("edge_err", RW'(res_err), RW'(1'b0));
    check_output("edge_data", res_data, 64'hFEDC_BA98_7654_3210);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset part-way through a load discards the partial vectors
    $display("[TB] reset mid-load");
    va = '{9, 9, 9, 9, 9, 9, 9, 9};
    for (int i = 0; i < 5; i++) send_word(va[i], 0);
    rst = 1'b1;
    #2;
    check_output("mid_rst_a0", RW'(a0), '0);
    check_output("mid_rst_ready", RW'(in_ready), RW'(1'b0));
    tick();
    rst = 1'b0;
    tick();
    check_output("mid_rst_no_start", RW'(start), RW'(1'b0));
    done   = 1'b1;
    result = 64'd55;
    tick();
    done = 1'b0;
    check_output("load_done_ignored", RW'(res_valid), RW'(1'b0));
    va = '{1, 2, 3, 4, 5, 6, 7, 8};
    vb = '{8, 7, 6, 5, 4, 3, 2, 1};
    apply_stimulus(0);
    finish_normal("after_rst", 64'd120);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dotprod_feeder.md
DOTPROD_FEEDER -- requirements
Module: dotprod_feeder

Interface
REQ-001 Parameter N, 8, vector length; elements per operand.
REQ-002 Parameter W, 32, element width in bits.
REQ-003 Parameter TIMEOUT, 200, maximum number of WAIT cycles allowed for done.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_ready  output  1  feeder accepts a word when in_valid&&in_ready.
REQ-008 in_data  input  W  stream word; words 0..N-1 are a[0..N-1], words N..2N-1 are b[0..N-1].
REQ-009 a0..a7, b0..b7  output  W each  operand registers driven to the downstream dotprod.
REQ-010 start  output  1  one-cycle pulse to dotprod.
REQ-011 done  input  1  dotprod completion.
REQ-012 result  input  2W  dotprod result, valid while done=1.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  consumer accepts the result when res_valid&&res_ready.
REQ-015 res_data  output  2W  captured result.
REQ-016 res_err  output  1  qualifies res_data; 1 = dotprod timed out.

Function
REQ-017 FSM SHALL have states LOAD, START, WAIT and OUT.
REQ-018 LOAD: in_ready=1; each accepted word SHALL be written to the operand selected by the word counter, and the counter SHALL increment.
REQ-019 When the word at index 2N-1 is accepted, the FSM SHALL go to START on the next edge and the counter SHALL clear to 0.
REQ-020 in_ready SHALL be 0 in START, WAIT and OUT; in_data SHALL be ignored there.
REQ-021 START: start=1 for exactly one cycle, then the FSM SHALL go to WAIT; done sampled in START SHALL be ignored.
REQ-022 a*/b* SHALL hold stable from START until the next LOAD write.
REQ-023 WAIT: when done=1, result SHALL be captured into res_data, res_err SHALL be set to 0, and the FSM SHALL go to OUT.
REQ-024 WAIT: the timeout counter SHALL increment each cycle with done=0.
REQ-025 WAIT timeout: at count TIMEOUT, res_data SHALL be set to 0, res_err SHALL be set to 1, and the FSM SHALL go to OUT.
REQ-026 If done=1 in the same cycle the timeout count is reached, done SHALL win (res_err=0).
REQ-027 OUT: res_valid=1, with res_data and res_err held, until res_ready=1; then res_valid SHALL drop on the next edge and the FSM SHALL return to LOAD.
REQ-028 Latency from the last input word to start SHALL be 1 cycle; from done to res_valid SHALL be 1 cycle.
REQ-029 done or result changes outside WAIT SHALL have no effect.
REQ-030 res_data SHALL be stored and passed through unmodified at 2W bits, with no truncation or sign handling.

Reset
REQ-031 Under rst=1: FSM=LOAD; counters=0; a*/b*=0; start=0; res_valid=0; res_data=0; res_err=0.
REQ-032 in_ready SHALL be 0 while rst=1 and SHALL become 1 on the first clock after rst deasserts.
REQ-033 Reset mid-load or mid-WAIT SHALL discard partial vectors and any pending result; no start or res_valid SHALL follow.

Structure
REQ-034 Package dotprod_pkg SHALL hold N, W, the result width 2W, TIMEOUT, and the FSM state enum.
REQ-035 The timeout counter SHALL be a sub-module, dp_timeout_cnt, with clear, enable and expired ports; everything else stays flat.
REQ-036 Word counter width SHALL be $clog2(2N).

Verification
REQ-037 Stream a=[2,7,5,3,5,6,7,8], b=[8,7,6,5,4,3,2,1] into the feeder connected to dotprod -> one start pulse; res_data=170, res_err=0.
REQ-038 Stream a=[1..8], b=[8..1], then a=[1..8], b=[0,1,0,1,0,1,0,1] back-to-back -> res_data=120, then 20; each start is exactly 1 cycle wide.
REQ-039 Random in_valid gaps plus res_ready held 0 for 5 cycles -> res_valid and res_data stable throughout; in_ready=0 until the result is taken.
REQ-040 Behavioural stub that never asserts done -> res_valid rises TIMEOUT+1 cycles after start with res_err=1 and res_data=0.
REQ-041 Assert rst after 5 input words, then stream a full 16-word vector set -> no spurious start; result matches the new vectors only.
REQ-042 Stub asserts done in the START cycle and again in WAIT -> only the WAIT-cycle result is captured.
